seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for an 8-digit common-anode 7-segment display; sits directly downstream of the binary-to-decimal converter and consumes its eight BCD digits.
- Captures a digit frame on a load strobe, commits it tear-free at frame boundaries, scans one digit at a time at a divided refresh rate, and drives active-low anode and segment lines.

Parameters:
- SCAN_DIV, 100000, clk cycles each digit stays lit; legal range 1..2^24-1; counter width is $clog2(SCAN_DIV+1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- load  input  1  single-cycle strobe; capture digits_in/dp_in into pending register
- digits_in  input  32  packed BCD; digit i = digits_in[4i+3:4i]; digit 0 is least significant and rightmost
- dp_in  input  8  decimal point enable per digit; bit i pairs with digit i
- an  output  8  active-low anode select; bit i enables digit i
- seg  output  8  active-low segments; bit7 = dp, bits6..0 = g,f,e,d,c,b,a
- frame_done  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0

Behaviour:
- The design has one clock and a synchronous, active-high reset. The clock port is clk and the reset port is rst. Reset is sampled only on a clk rising edge.
- Reset values:
  - div_cnt = 0, scan_idx = 0
  - disp_digits = 0, disp_dp = 0, pend_valid = 0
  - an = 8'hFF (all digits off), seg = 8'hFF, frame_done = 0
- Divider: div_cnt counts 0..SCAN_DIV-1. The cycle where div_cnt == SCAN_DIV-1 is a "tick". On a tick, div_cnt returns to 0 and scan_idx increments modulo 8 (7 -> 0). With SCAN_DIV = 1, every cycle is a tick.
- Outputs are registered with one-cycle latency from scan_idx and the display registers:
  - an = ~(8'b1 << scan_idx)
  - seg = decode(disp_digits[scan_idx]) with bit7 = ~disp_dp[scan_idx]
  - First cycle after rst deasserts: an = 8'hFE, showing digit 0 of the zeroed frame (seg = 8'hC0).
- Decode table (active-low {g..a}, dp off):
  - 0 -> C0, 1 -> F9, 2 -> A4, 3 -> B0, 4 -> 99
  - 5 -> 92, 6 -> 82, 7 -> F8, 8 -> 80, 9 -> 90
  - Codes 10..15 are illegal and display '-' (8'hBF).
- Load:
  - When load = 1, pend_digits <= digits_in, pend_dp <= dp_in, pend_valid <= 1.
  - Back-to-back loads overwrite pending; the last one wins.
- Commit: on the tick where scan_idx == 7 (frame wrap):
  - If pend_valid, then disp <= pend and pend_valid <= 0.
  - A new frame therefore always starts at digit 0 and is never shown partially.
- Simultaneous load and commit tick: digits_in/dp_in go straight to disp, and pend_valid <= 0. Incoming data wins over the older pending value.
- frame_done asserts for exactly one cycle. It is registered and aligned with the cycle in which the committed frame's digit 0 first appears on an/seg.
- Reset asserted mid-frame or mid-digit: all state returns to reset values on the next edge, and any pending frame is discarded.
- Only one anode is ever low. an is never all-high except during reset.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most significant nonzero digit of disp_digits show seg = 8'hFF (dp also off).
  - Their anode is still scanned, so brightness stays uniform.
  - Digit 0 is never blanked, so the value 0 shows as a single "0".
  - The blank mask is computed combinationally from disp_digits and applied in the same registered seg stage, so latency is unchanged.
- Undefined: all 8 digits always display, including leading zeros.

Test Plan:
- SCAN_DIV = 4, reset released -> an steps FE, FD, FB, ... 7F every 4 cycles, then back to FE; seg = C0 on every digit; frame_done pulses once per 32 cycles.
- load with digits_in = 32'h12345678, dp_in = 8'h04 mid-frame -> display unchanged until wrap; next frame shows digit 0 = 80, digit 1 = F8, digit 2 = 02 (dp lit), ..., digit 7 = F9.
- load on the exact commit tick (scan_idx = 7, div_cnt = 3) with 32'h00000009 -> the next frame shows 9 on digit 0 with no one-frame delay, and pend_valid = 0 afterwards.
- digits_in = 32'hA0000000 loaded -> digit 7 shows BF; all other digits show C0 (macro undefined).
- SEG7_LEADING_ZERO_BLANK_EN defined, digits_in = 32'h00000305 -> digits 3..7 show FF, digit 2 = B0, digit 1 = C0, digit 0 = 92; value 0 -> only digit 0 shows C0.
- rst pulsed while scan_idx = 5 with a pending load -> next cycle an = FF, seg = FF; after release the display shows the zero frame, and the pending data never appears.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Digit-frame and display-line bundle between the BCD source and seg7_scan_driver.
// master = frame source side, slave = scan driver side.
interface seg7_scan_driver_if;
    logic        load;
    logic [31:0] digits_in;
    logic [7:0]  dp_in;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    modport master (
        output load, digits_in, dp_in,
        input  an, seg, frame_done
    );

    modport slave (
        input  load, digits_in, dp_in,
        output an, seg, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment driver with tear-free frame commit.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input logic              clk,
    input logic              rst,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned CW = $clog2(SCAN_DIV + 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]    scan_idx_q, scan_idx_d;
    logic [31:0]   pend_digits_q, pend_digits_d;
    logic [7:0]    pend_dp_q, pend_dp_d;
    logic          pend_valid_q, pend_valid_d;
    logic [31:0]   disp_digits_q, disp_digits_d;
    logic [7:0]    disp_dp_q, disp_dp_d;
    logic          wrap_q;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_done_q;
    logic          tick;
    logic          wrap;
    logic [3:0]    cur_digit;

    // Active-low {g,f,e,d,c,b,a}; illegal codes show a dash (only g lit).
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    always_comb begin
        tick          = (div_cnt_q == CW'(SCAN_DIV - 1));
        wrap          = tick && (scan_idx_q == 3'd7);
        div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
        scan_idx_d    = tick ? scan_idx_q + 3'd1 : scan_idx_q;
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_valid_d  = pend_valid_q;
        disp_digits_d = disp_digits_q;
        disp_dp_d     = disp_dp_q;
        if (wrap && bus.load) begin
            // Fresh data arriving on the wrap tick supersedes anything pending.
            disp_digits_d = bus.digits_in;
            disp_dp_d     = bus.dp_in;
            pend_valid_d  = 1'b0;
        end else if (bus.load) begin
            pend_digits_d = bus.digits_in;
            pend_dp_d     = bus.dp_in;
            pend_valid_d  = 1'b1;
        end else if (wrap && pend_valid_q) begin
            disp_digits_d = pend_digits_q;
            disp_dp_d     = pend_dp_q;
            pend_valid_d  = 1'b0;
        end
    end

    assign cur_digit = disp_digits_q[{scan_idx_q, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0] blank;

    // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic run;
        blank = '0;
        run   = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            run      = run & (disp_digits_q[4*i +: 4] == 4'd0);
            blank[i] = run;
        end
    end

    always_comb begin
        an_d  = ~(8'd1 << scan_idx_q);
        seg_d = blank[scan_idx_q] ? 8'hFF : {~disp_dp_q[scan_idx_q], decode(cur_digit)};
    end
`else
    always_comb begin
        an_d  = ~(8'd1 << scan_idx_q);
        seg_d = {~disp_dp_q[scan_idx_q], decode(cur_digit)};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            scan_idx_q    <= 3'd0;
            pend_digits_q <= 32'd0;
            pend_dp_q     <= 8'd0;
            pend_valid_q  <= 1'b0;
            disp_digits_q <= 32'd0;
            disp_dp_q     <= 8'd0;
            wrap_q        <= 1'b0;
            an_q          <= 8'hFF;
            seg_q         <= 8'hFF;
            frame_done_q  <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            scan_idx_q    <= scan_idx_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            disp_digits_q <= disp_digits_d;
            disp_dp_q     <= disp_dp_d;
            // Delayed one stage so the pulse lines up with the new frame's digit 0 on an/seg.
            wrap_q        <= wrap;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_done_q  <= wrap_q;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at SCAN_DIV = 4 (32-cycle frames).
// Expectations follow SEG7_LEADING_ZERO_BLANK_EN when it is defined.
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic rst;
    int   compared = 0;
    int   mismatched = 0;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one 32-cycle frame; optionally strobes load so it is sampled at cycle load_k.
    task automatic run_frame(input string name, input logic [63:0] exp, input logic exp_done,
                             input int load_k, input logic [31:0] ld_d, input logic [7:0] ld_p);
        logic [7:0] exp_an;
        for (int k = 0; k < 32; k++) begin
            if (k == load_k) begin
                bus.load      = 1'b1;
                bus.digits_in = ld_d;
                bus.dp_in     = ld_p;
            end
            cycle();
            bus.load = 1'b0;
            if (k % 4 == 0) begin
                exp_an = 8'd1 << (k / 4);
                exp_an = ~exp_an;
                chk($sformatf("%s d%0d an", name, k / 4), bus.an, exp_an);
                chk($sformatf("%s d%0d seg", name, k / 4), bus.seg, exp[8*(k/4) +: 8]);
            end
            if (k == 0)
                chk({name, " frame_done first"}, {7'd0, bus.frame_done}, {7'd0, exp_done});
            if (k == 1)
                chk({name, " frame_done second"}, {7'd0, bus.frame_done}, 8'd0);
        end
    endtask

    logic [63:0] f_zero, f_c, f_d, f_f, f_g, f_h;

    initial begin
        f_c = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h02, 8'hF8, 8'h80};
        f_f = {8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        f_zero = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0};
        f_d    = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h90};
        f_g    = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hB0, 8'hC0, 8'h92};
        f_h    = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40};
`else
        f_zero = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        f_d    = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h90};
        f_g    = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hB0, 8'hC0, 8'h92};
        f_h    = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'h40};
`endif

        rst           = 1'b1;
        bus.load      = 1'b0;
        bus.digits_in = 32'd0;
        bus.dp_in     = 8'd0;
        repeat (3) cycle();
        chk("reset an", bus.an, 8'hFF);
        chk("reset seg", bus.seg, 8'hFF);
        chk("reset frame_done", {7'd0, bus.frame_done}, 8'd0);
        rst = 1'b0;

        // Zero frame after release; load mid-frame B must not show until frame C.
        run_frame("frmA", f_zero, 1'b0, -1, 32'd0, 8'd0);
        run_frame("frmB", f_zero, 1'b1, 10, 32'h12345678, 8'h04);
        // Load on the exact commit tick goes straight to the next frame.
        run_frame("frmC", f_c, 1'b1, 31, 32'h00000009, 8'h00);
        run_frame("frmD", f_d, 1'b1, -1, 32'd0, 8'd0);
        chk("pend_valid after direct commit", {7'd0, dut.pend_valid_q}, 8'd0);
        run_frame("frmE", f_d, 1'b1, 20, 32'hA0000000, 8'h00);
        run_frame("frmF", f_f, 1'b1, 3, 32'h00000305, 8'h00);
        run_frame("frmG", f_g, 1'b1, 7, 32'h00000000, 8'h03);
        run_frame("frmH", f_h, 1'b1, 8, 32'h87654321, 8'hFF);

        // Reset while digit 5 is lit and a frame is pending.
        for (int k = 0; k < 22; k++) begin
            if (k == 12) begin
                bus.load      = 1'b1;
                bus.digits_in = 32'h13572468;
                bus.dp_in     = 8'hAA;
            end
            cycle();
            bus.load = 1'b0;
        end
        chk("pre-reset an digit5", bus.an, 8'hDF);
        rst = 1'b1;
        cycle();
        chk("midreset an", bus.an, 8'hFF);
        chk("midreset seg", bus.seg, 8'hFF);
        chk("midreset frame_done", {7'd0, bus.frame_done}, 8'd0);
        rst = 1'b0;
        run_frame("postrstA", f_zero, 1'b0, -1, 32'd0, 8'd0);
        run_frame("postrstB", f_zero, 1'b1, -1, 32'd0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
